// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: issue controller, per-register pending scoreboard and
// FP register-file write-port arbiter for the multi-cycle FP unit.
module fpu_scoreboard #(
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 12,
   parameter int SQRT_LAT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_d,
   input  logic [1:0]  fop_d,
   input  logic [4:0]  frd_d,
   input  logic [4:0]  frs1_d,
   input  logic [4:0]  frs2_d,
   input  logic        fuse_rs1_d,
   input  logic        fuse_rs2_d,
   input  logic        fwrite_d,
   input  logic        stall_d_in,
   input  logic [31:0] fpu_result,
   input  logic        wb_pipe_we,
   input  logic [4:0]  wb_pipe_rd,
   input  logic [31:0] wb_pipe_data,
   output logic        fpu_stall,
   output logic        fpu_start,
   output logic        fpu_en,
   output logic [1:0]  fpu_op,
   output logic        frf_we,
   output logic [4:0]  frf_waddr,
   output logic [31:0] frf_wdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [4:0] MUL_INIT  = 5'(MUL_LAT - 1);
   localparam logic [4:0] DIV_INIT  = 5'(DIV_LAT - 1);
   localparam logic [4:0] SQRT_INIT = 5'(SQRT_LAT - 1);

   state_t      state_q, state_d;
   logic [31:0] sb_q, sb_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] res_q, res_d;
   logic [1:0]  op_q, op_d;
   logic [4:0]  lat_init;
   logic        reserved_op;
   logic        accept;
   logic        fp_grant;

   // Hazard detection and accept decision; reserved ops neither stall nor issue.
   always_comb begin
      reserved_op = (fop_d == 2'b11);
      fpu_stall   = (fuse_rs1_d && sb_q[frs1_d])
                 || (fuse_rs2_d && sb_q[frs2_d])
                 || (fwrite_d   && sb_q[frd_d])
                 || (issue_d && !reserved_op && (state_q != IDLE));
      accept      = issue_d && !fpu_stall && !stall_d_in && !reserved_op;
      fpu_start   = accept;
      unique case (fop_d)
         2'b00:   lat_init = MUL_INIT;
         2'b01:   lat_init = DIV_INIT;
         default: lat_init = SQRT_INIT;
      endcase
   end

   // Sequencer next-state: accept in IDLE, count down in RUN, retire in WB.
   always_comb begin
      state_d = state_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      res_d   = res_q;
      op_d    = op_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d         = fop_d;
               rd_d         = frd_d;
               sb_d[frd_d]  = 1'b1;
               cnt_d        = lat_init;
               state_d      = RUN;
            end
         end
         RUN: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               res_d   = fpu_result;
               state_d = WB;
            end
         end
         WB: begin
            // The W stage cannot stall, so it always wins the write port.
            if (!wb_pipe_we) begin
               sb_d[rd_q] = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register-file write-port mux and status outputs.
   always_comb begin
      fp_grant = (state_q == WB) && !wb_pipe_we;
      fpu_en   = (state_q == RUN);
      busy     = (state_q != IDLE);
      fpu_op   = op_q;
      if (fp_grant) begin
         frf_we    = 1'b1;
         frf_waddr = rd_q;
         frf_wdata = res_q;
      end else begin
         frf_we    = wb_pipe_we;
         frf_waddr = wb_pipe_rd;
         frf_wdata = wb_pipe_data;
      end
   end

   // State registers with synchronous reset; reset abandons any in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sb_q    <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
         op_q    <= op_d;
      end
   end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb_fpu_scoreboard: directed stimulus for fpu_scoreboard with a write-port
// scoreboard (expected writes queued by cycle, checked by a monitor).
`timescale 1ns/1ps
module tb_fpu_scoreboard;

   logic        clk;
   logic        reset;
   logic        issue_d;
   logic [1:0]  fop_d;
   logic [4:0]  frd_d, frs1_d, frs2_d;
   logic        fuse_rs1_d, fuse_rs2_d, fwrite_d, stall_d_in;
   logic [31:0] fpu_result;
   logic        wb_pipe_we;
   logic [4:0]  wb_pipe_rd;
   logic [31:0] wb_pipe_data;
   logic        fpu_stall, fpu_start, fpu_en;
   logic [1:0]  fpu_op;
   logic        frf_we;
   logic [4:0]  frf_waddr;
   logic [31:0] frf_wdata;
   logic        busy;

   fpu_scoreboard #(.MUL_LAT(3), .DIV_LAT(12), .SQRT_LAT(16)) dut (
      .clk(clk), .reset(reset), .issue_d(issue_d), .fop_d(fop_d),
      .frd_d(frd_d), .frs1_d(frs1_d), .frs2_d(frs2_d),
      .fuse_rs1_d(fuse_rs1_d), .fuse_rs2_d(fuse_rs2_d), .fwrite_d(fwrite_d),
      .stall_d_in(stall_d_in), .fpu_result(fpu_result),
      .wb_pipe_we(wb_pipe_we), .wb_pipe_rd(wb_pipe_rd), .wb_pipe_data(wb_pipe_data),
      .fpu_stall(fpu_stall), .fpu_start(fpu_start), .fpu_en(fpu_en),
      .fpu_op(fpu_op), .frf_we(frf_we), .frf_waddr(frf_waddr),
      .frf_wdata(frf_wdata), .busy(busy)
   );

   typedef struct {
      int          cyc;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  vectors    = 0;
   int  miscompares = 0;
   int  cyc        = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Keep the expected-write queue ordered by cycle.
   task automatic push_wr(input int c, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      int  i;
      e.cyc = c; e.addr = a; e.data = d;
      i = 0;
      while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
      exp_q.insert(i, e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
      issue_d = 1'b0; fop_d = 2'b00; frd_d = '0; frs1_d = '0; frs2_d = '0;
      fuse_rs1_d = 1'b0; fuse_rs2_d = 1'b0; fwrite_d = 1'b0; stall_d_in = 1'b0;
      fpu_result = 32'hDEADBEEF;
      wb_pipe_we = 1'b0; wb_pipe_rd = '0; wb_pipe_data = '0;
   endtask

   task automatic settle();
      #2;
   endtask

   // Monitor: every port write must match the queued write for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         vectors++;
         miscompares++;
         $display("FAIL missing_write: got none expected addr %0d data %h (cycle %0d)",
                  exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (frf_we === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr %0d data %h expected no write (cycle %0d)",
                     frf_waddr, frf_wdata, cyc);
         end else begin
            if (frf_waddr !== exp_q[0].addr || frf_wdata !== exp_q[0].data) begin
               miscompares++;
               $display("FAIL write_port: got addr %0d data %h expected addr %0d data %h (cycle %0d)",
                        frf_waddr, frf_wdata, exp_q[0].addr, exp_q[0].data, cyc);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int a, b, c, d;
      reset = 1'b1;
      next_cycle();
      next_cycle();
      fuse_rs1_d = 1'b1; frs1_d = 5'd0; fuse_rs2_d = 1'b1; frs2_d = 5'd31;
      settle();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_op", 32'(fpu_op), 32'd0);
      chk("reset_en", 32'(fpu_en), 32'd0);
      chk("reset_stall", 32'(fpu_stall), 32'd0);
      chk("reset_we", 32'(frf_we), 32'd0);
      reset = 1'b0;

      // FDIV f3, result written at A+13, sb[3] clear from A+14.
      next_cycle();
      a = cyc;
      issue_d = 1'b1; fop_d = 2'b01; frd_d = 5'd3;
      settle();
      chk("div_start", 32'(fpu_start), 32'd1);
      chk("div_accept_busy", 32'(busy), 32'd0);
      push_wr(a + 13, 5'd3, 32'h40490FDB);
      for (int k = 1; k <= 12; k++) begin
         next_cycle();
         if (k == 12) fpu_result = 32'h40490FDB;
         if (k == 5) begin
            wb_pipe_we = 1'b1; wb_pipe_rd = 5'd20; wb_pipe_data = 32'h12345678;
            push_wr(cyc, 5'd20, 32'h12345678);
         end
         if (k == 2) begin
            fwrite_d = 1'b1; frd_d = 5'd3;
         end
         settle();
         chk("div_run_en", 32'(fpu_en), 32'd1);
         chk("div_run_op", 32'(fpu_op), 32'd1);
         chk("div_run_start", 32'(fpu_start), 32'd0);
         if (k == 2) chk("div_waw_stall", 32'(fpu_stall), 32'd1);
      end
      next_cycle();
      fuse_rs1_d = 1'b1; frs1_d = 5'd3;
      settle();
      chk("div_wb_raw_stall", 32'(fpu_stall), 32'd1);
      chk("div_wb_en", 32'(fpu_en), 32'd0);
      next_cycle();
      fuse_rs1_d = 1'b1; frs1_d = 5'd3;
      settle();
      chk("div_after_stall", 32'(fpu_stall), 32'd0);
      chk("div_after_busy", 32'(busy), 32'd0);

      // FMUL f5 with a dependent FADD in decode.
      next_cycle();
      b = cyc;
      issue_d = 1'b1; fop_d = 2'b00; frd_d = 5'd5;
      settle();
      chk("mul_start", 32'(fpu_start), 32'd1);
      push_wr(b + 4, 5'd5, 32'h41200000);
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         if (k == 2) begin
            fwrite_d = 1'b1; frd_d = 5'd5;
         end else begin
            fuse_rs1_d = 1'b1; frs1_d = 5'd6; fuse_rs2_d = 1'b1; frs2_d = 5'd5;
            fwrite_d = 1'b1; frd_d = 5'd9;
         end
         if (k == 3) fpu_result = 32'h41200000;
         settle();
         chk("mul_dep_stall", 32'(fpu_stall), 32'd1);
      end
      next_cycle();
      fuse_rs1_d = 1'b1; frs1_d = 5'd6; fuse_rs2_d = 1'b1; frs2_d = 5'd5;
      fwrite_d = 1'b1; frd_d = 5'd9;
      settle();
      chk("mul_dep_release", 32'(fpu_stall), 32'd0);

      // FSQRT f10, then a structurally blocked FMUL f11 that later meets W-stage writes.
      next_cycle();
      c = cyc;
      issue_d = 1'b1; fop_d = 2'b10; frd_d = 5'd10;
      settle();
      chk("sqrt_start", 32'(fpu_start), 32'd1);
      push_wr(c + 17, 5'd10, 32'h3FB504F3);
      for (int k = 1; k <= 17; k++) begin
         next_cycle();
         issue_d = 1'b1; fop_d = 2'b00; frd_d = 5'd11;
         if (k == 16) fpu_result = 32'h3FB504F3;
         settle();
         chk("struct_stall", 32'(fpu_stall), 32'd1);
         chk("struct_no_start", 32'(fpu_start), 32'd0);
      end
      next_cycle();
      issue_d = 1'b1; fop_d = 2'b00; frd_d = 5'd11; stall_d_in = 1'b1;
      settle();
      chk("held_stall", 32'(fpu_stall), 32'd0);
      chk("held_no_start", 32'(fpu_start), 32'd0);
      next_cycle();
      issue_d = 1'b1; fop_d = 2'b00; frd_d = 5'd11;
      settle();
      chk("mul2_start", 32'(fpu_start), 32'd1);
      push_wr(c + 25, 5'd11, 32'h40C00000);
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         if (k == 3) fpu_result = 32'h40C00000;
         settle();
         chk("mul2_en", 32'(fpu_en), 32'd1);
      end
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         wb_pipe_we = 1'b1; wb_pipe_rd = 5'd7; wb_pipe_data = 32'h3F800000;
         push_wr(cyc, 5'd7, 32'h3F800000);
         settle();
         chk("wb_hold_busy", 32'(busy), 32'd1);
      end
      next_cycle();
      settle();
      chk("wb_write_busy", 32'(busy), 32'd1);
      next_cycle();
      settle();
      chk("wb_done_busy", 32'(busy), 32'd0);

      // Reset during RUN abandons the FDIV f8 (cnt=5 in cycle d+7).
      next_cycle();
      d = cyc;
      issue_d = 1'b1; fop_d = 2'b01; frd_d = 5'd8;
      settle();
      chk("rst_div_start", 32'(fpu_start), 32'd1);
      for (int k = 1; k <= 7; k++) begin
         next_cycle();
         if (k == 7) reset = 1'b1;
      end
      next_cycle();
      reset = 1'b0;
      fuse_rs1_d = 1'b1; frs1_d = 5'd8;
      wb_pipe_we = 1'b1; wb_pipe_rd = 5'd2; wb_pipe_data = 32'hAABBCCDD;
      push_wr(cyc, 5'd2, 32'hAABBCCDD);
      settle();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sb_clear", 32'(fpu_stall), 32'd0);
      chk("rst_op", 32'(fpu_op), 32'd0);
      chk("rst_en", 32'(fpu_en), 32'd0);
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         fpu_result = 32'h0BADF00D;
         settle();
         chk("rst_idle_busy", 32'(busy), 32'd0);
      end

      // Reserved op: no start, no stall, stays idle.
      next_cycle();
      issue_d = 1'b1; fop_d = 2'b11; frd_d = 5'd4;
      settle();
      chk("rsv_start", 32'(fpu_start), 32'd0);
      chk("rsv_stall", 32'(fpu_stall), 32'd0);
      next_cycle();
      issue_d = 1'b1; fop_d = 2'b11; frd_d = 5'd4; fwrite_d = 1'b1;
      settle();
      chk("rsv_busy", 32'(busy), 32'd0);
      chk("rsv_no_sb", 32'(fpu_stall), 32'd0);

      for (int k = 0; k < 3; k++) next_cycle();
      settle();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
